// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared types and constants for the bit-serial adder sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

  // Operand width used when the instantiating level does not override it.
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit counter width for the default operand width.
  localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  // Sequencer states, explicitly two bits wide.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width for a given operand width: counts 0 .. w-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/serial_fa_cell.sv
`default_nettype none
// ============================================================================
// Module   : serial_fa_cell
// Purpose  : Stateless one-bit full adder shared across all bit positions.
// Revision : 1.0 - initial release
// ============================================================================
module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  // Sum is the three-way parity, carry is the majority of the inputs.
  always_comb begin
    s_o  = a_i ^ b_i ^ ci_i;
    co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
  end

endmodule : serial_fa_cell
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial add sequencer. Operands arrive on a valid/ready
//            handshake, one bit pair per cycle (LSB first) passes through a
//            single full-adder cell, and the assembled sum plus carry-out is
//            offered on a second valid/ready handshake.
// Options  : SERIAL_ADD_SUB_EN - adds the 'sub' port; when latched high the
//            B operand is inverted at the cell and the carry starts at 1,
//            giving A - B with cout = 1 meaning no borrow.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned     CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] s_sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             fa_b;
  logic             fa_s;
  logic             fa_co;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;

  // Subtraction is A + ~B + 1: invert B at the cell input only.
  always_comb fa_b = b_sr_q[0] ^ sub_q;

  // Remember the operation kind for the whole serial pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else if (state_q == ST_IDLE && in_valid) begin
      sub_q <= sub;
    end
  end
`else
  // Add-only build: B goes straight into the cell.
  always_comb fa_b = b_sr_q[0];
`endif

  serial_fa_cell u_fa (
    .a_i  (a_sr_q[0]),
    .b_i  (fa_b),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: capture, WIDTH serial steps, then hold until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)           state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_LAST)  state_d = ST_DONE;
      ST_DONE: if (out_ready)          state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on inputs directly.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
    sum  = s_sr_q;
    cout = carry_q;
  end

  // Datapath: load operands in IDLE, shift one bit pair per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_sr_q <= op_a;
            b_sr_q <= op_b;
            cnt_q  <= '0;
`ifdef SERIAL_ADD_SUB_EN
            carry_q <= sub ? 1'b1 : cin;
`else
            carry_q <= cin;
`endif
          end
        end
        ST_RUN: begin
          s_sr_q  <= {fa_s, s_sr_q[WIDTH-1:1]};
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Self-checking bench for serial_add_ctrl (WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         s;
    logic [W-1:0] esum;
    logic         ecout;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
  } res_t;

  vec_t vecs[$];
  res_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one operand pair for a single edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic s, input logic [W-1:0] es, input logic ec);
    int t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    chk("in_ready_before_op", in_ready, 1);
    op_a = a; op_b = b; cin = c; sub = s;
    in_valid = 1'b1;
    sb.push_back('{es, ec});
    tick();
    in_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
    chk("busy_in_run", busy, 1);
    chk("in_ready_in_run", in_ready, 0);
  endtask

  // Counts edges from the operand handshake to out_valid and checks the result.
  task automatic wait_result();
    int   e = 0;
    res_t r;
    while (!out_valid && e < 4*W) begin
      tick();
      e++;
    end
    chk("latency", e, W);
    chk("busy_in_done", busy, 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      r = sb.pop_front();
      chk("sum", sum, r.sum);
      chk("cout", cout, r.cout);
    end
  endtask

  // With out_ready high, the block must be idle and ready one edge later.
  task automatic finish_result();
    tick();
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0]   m;
    logic [W-1:0] ra[4];
    logic [W-1:0] rb[4];
    logic         seen_ov;
    int           k, got, cyc, last;
    res_t         r;

    // Directed vectors with hand-computed results.
    vecs.push_back('{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
    vecs.push_back('{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1});
    vecs.push_back('{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0});
`endif
    // A few random adds checked against the reference model.
    for (int i = 0; i < 3; i++) begin
      vec_t v;
      v.a = W'($urandom); v.b = W'($urandom); v.c = 1'($urandom); v.s = 1'b0;
      m = model(v.a, v.b, v.c, v.s);
      v.esum = m[W-1:0]; v.ecout = m[W];
      vecs.push_back(v);
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].esum, vecs[i].ecout);
      wait_result();
      finish_result();
    end

    // Consumer stalls 5 cycles in DONE while new operands are already offered.
    out_ready = 1'b0;
    start_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);
    wait_result();
    op_a = 8'h01; op_b = 8'h01; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_sum", sum, 8'h46);
      chk("hold_cout", cout, 0);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    sb.push_back('{8'h02, 1'b0});
    tick();
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("pending_accepted", busy, 1);
    wait_result();
    finish_result();

    // Reset during the 4th RUN cycle discards the operation.
    start_op(8'h77, 8'h11, 1'b0, 1'b0, 8'h88, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sum", sum, 0);
    seen_ov = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen_ov = 1'b1;
    end
    chk("midrst_no_out_valid", seen_ov, 0);
    sb.delete();
    start_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);
    wait_result();
    finish_result();

    // Reset and in_valid together: reset wins, nothing captured.
    rst = 1'b1; in_valid = 1'b1; op_a = 8'h05; op_b = 8'h06;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_vs_valid_busy", busy, 0);
    tick();
    chk("rst_vs_valid_idle", in_ready, 1);

    // Back-to-back stream with in_valid and out_ready held high.
    for (int i = 0; i < 4; i++) begin
      ra[i] = W'($urandom);
      rb[i] = W'($urandom);
    end
    k = 0; got = 0; cyc = 0; last = -1;
    out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1; op_a = ra[0]; op_b = rb[0];
    while (got < 4 && cyc < 200) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("b2b_scoreboard_empty", 0, 1);
        end else begin
          r = sb.pop_front();
          chk("b2b_sum", sum, r.sum);
          chk("b2b_cout", cout, r.cout);
        end
        if (last >= 0) chk("b2b_spacing", cyc - last, W + 2);
        last = cyc;
        got++;
      end
      if (in_ready) begin
        if (k < 4) begin
          op_a = ra[k]; op_b = rb[k]; in_valid = 1'b1;
          m = model(ra[k], rb[k], 1'b0, 1'b0);
          sb.push_back('{m[W-1:0], m[W]});
          k++;
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("b2b_count", got, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_add_ctrl
`default_nettype wire
